auth_controller: RTL
====================

Name: auth_controller

Overview:
Player login block that drives the LoggedIn / PlayerID interface consumed by the game controller and score tracker. The player keys a 5-bit player ID and then a 4-digit hex password on SwPass, committing each digit with a shaped BtPass pulse. The block checks the entry against a fixed password table and asserts LoggedIn with a valid PlayerID. It locks out entry after repeated failures, and it supports logout while no game is running.

Parameters:
NUM_PLAYERS, 8, valid player IDs are 1..NUM_PLAYERS; ID 0 means "nobody"
MAX_FAILS, 3, consecutive failed checks that trigger lockout (1..7)
LOCK_CYCLES, 50000000, lockout duration in clock cycles (1 s at 50 MHz); counter width is clog2(LOCK_CYCLES+1)

Ports:
Clk  input  1  system clock
Rst  input  1  synchronous reset, active-low
SwPass  input  4  current digit value
BtPass  input  1  one-cycle shaped pulse: commit SwPass as next digit
BtLogout  input  1  one-cycle shaped pulse: cancel entry or log out
GameBusy  input  1  high while a game is in progress; blocks logout
LoggedIn  output  1  high while a player is authenticated
PlayerID  output  5  authenticated ID; 0 when LoggedIn=0
AuthState  output  3  FSM state code, for display and debug
DigitCount  output  3  password digits entered so far (0..4)
AuthFail  output  1  one-cycle pulse on failed check
Locked  output  1  high during lockout

Behaviour:
- Reset (Rst=0 at a rising edge) sets:
  - state to ID_HI, LoggedIn=0, PlayerID=0, DigitCount=0, AuthFail=0, Locked=0
  - fail counter=0, lock counter=0, digit and ID registers=0
- All outputs are registered.
- FSM states and AuthState codes: ID_HI=0, ID_LO=1, PW=2, CHECK=3, GRANTED=4, LOCKED=5.
- ID_HI: on BtPass, capture SwPass[0] as ID[4] (SwPass[3:1] ignored) and go to ID_LO.
- ID_LO: on BtPass, capture SwPass as ID[3:0] and go to PW with DigitCount=0.
- PW:
  - Each BtPass stores SwPass into digit slot DigitCount and increments DigitCount.
  - The press that makes DigitCount=4 moves the FSM to CHECK on the same edge.
- CHECK lasts exactly one cycle and compares all four digits at once, with no early exit.
- Expected password for ID k, in digit order 0..3:
  - k[3:0]
  - ~k[3:0]
  - k[3:0]^4'hA
  - 4'h5^{3'b0,k[4]}
- An ID outside 1..NUM_PLAYERS always fails. Its password entry is still accepted digit by digit, so the failure does not reveal that the ID was invalid.
- CHECK pass:
  - next edge enters GRANTED with LoggedIn=1 and PlayerID=ID
  - fail counter cleared, DigitCount cleared
  - latency from the 4th BtPass edge to LoggedIn=1 is 2 cycles
- CHECK fail:
  - AuthFail pulses for 1 cycle, concurrent with leaving CHECK
  - fail counter increments, DigitCount cleared, ID register cleared
  - if the fail counter reaches MAX_FAILS, go to LOCKED; otherwise go to ID_HI
- GRANTED:
  - BtPass is ignored.
  - BtLogout with GameBusy=0 goes to ID_HI, with LoggedIn=0 and PlayerID=0 on the next cycle.
  - BtLogout with GameBusy=1 is ignored.
- LOCKED:
  - Locked=1; all buttons are ignored.
  - The lock counter loads LOCK_CYCLES-1 on entry and decrements every cycle.
  - When it reads 0, go to ID_HI with Locked=0 and the fail counter cleared. LOCKED therefore lasts exactly LOCK_CYCLES cycles.
- Cancel: BtLogout in ID_HI, ID_LO or PW returns to ID_HI. It clears DigitCount and the ID/digit registers and does not count as a failure.
- Simultaneous BtPass and BtLogout in the same cycle: BtLogout has priority in every state.
- Reset mid-entry or mid-lockout returns to reset values. The fail count is not preserved across reset.

Optional Feature:
Macro AUTH_ENTRY_TIMEOUT_EN.
- Defined:
  - Parameter TIMEOUT_CYCLES (default 500000000) is added.
  - An idle counter runs in ID_LO and PW, is cleared on every BtPass and on state entry, and resets to 0 in all other states.
  - On reaching TIMEOUT_CYCLES-1, the FSM returns to ID_HI with cancel semantics (no AuthFail, no fail count).
- Not defined: no counter exists, and a partial entry persists indefinitely.

Test Plan:
- Login for ID 1, parameters at defaults: reset; enter ID digits 0,1, then password 1,E,B,5 -> DigitCount steps 1..4; AuthState goes 3 then 4; LoggedIn=1 and PlayerID=5'd1 two cycles after the 4th press.
- Wrong password and lockout, with LOCK_CYCLES=10: ID 1 with password 1,E,B,4 -> one AuthFail pulse, AuthState=0, LoggedIn stays 0. Three such failures in a row -> Locked=1 for exactly 10 cycles; a correct entry attempted during lock has no effect. After release, AuthState=0 and the fail counter is 0.
- Invalid ID: ID 0 with password 0,F,A,5, then ID 9 (NUM_PLAYERS=8) with password 9,6,3,5 -> AuthFail both times; LoggedIn=0.
- Logout gating: logged in as ID 1. BtLogout with GameBusy=1 -> still logged in. BtLogout with GameBusy=0 -> LoggedIn=0 and PlayerID=0 next cycle.
- Cancel and priority: in PW with DigitCount=2, assert BtPass and BtLogout in the same cycle -> AuthState=0, DigitCount=0, no AuthFail; a following correct full entry succeeds.
- With AUTH_ENTRY_TIMEOUT_EN and TIMEOUT_CYCLES=20: stop after 2 password digits -> AuthState=0 after 20 idle cycles with no AuthFail. A press at cycle 19 restarts the count.

Source files
------------

// File: rtl/auth_controller.sv
// auth_controller: player login FSM (ID entry, 4-digit password check, lockout, logout).
// Optional feature: define AUTH_ENTRY_TIMEOUT_EN to abandon stalled entries after TIMEOUT_CYCLES.
module auth_controller #(
    parameter int NUM_PLAYERS = 8,
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYCLES = 50000000
`ifdef AUTH_ENTRY_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 500000000
`endif
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [3:0] SwPass,
    input  logic       BtPass,
    input  logic       BtLogout,
    input  logic       GameBusy,
    output logic       LoggedIn,
    output logic [4:0] PlayerID,
    output logic [2:0] AuthState,
    output logic [2:0] DigitCount,
    output logic       AuthFail,
    output logic       Locked
);

    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [LOCK_W-1:0] LOCK_LOAD  = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [5:0]        MAX_ID     = 6'(NUM_PLAYERS);
    localparam logic [2:0]        FAIL_LIMIT = 3'(MAX_FAILS);

    typedef enum logic [2:0] {
        ST_ID_HI   = 3'd0,
        ST_ID_LO   = 3'd1,
        ST_PW      = 3'd2,
        ST_CHECK   = 3'd3,
        ST_GRANTED = 3'd4,
        ST_LOCKED  = 3'd5
    } state_t;

    state_t            r_state;
    logic [4:0]        r_id;
    logic [3:0][3:0]   r_digits;
    logic [2:0]        r_dcnt;
    logic [2:0]        r_fails;
    logic [LOCK_W-1:0] r_lock_cnt;
    logic              r_logged_in;
    logic [4:0]        r_player_id;
    logic              r_auth_fail;
    logic              r_locked;

    state_t            w_state_nxt;
    logic [4:0]        w_id_nxt;
    logic [3:0][3:0]   w_digits_nxt;
    logic [2:0]        w_dcnt_nxt;
    logic [2:0]        w_fails_nxt;
    logic [LOCK_W-1:0] w_lock_nxt;
    logic              w_logged_nxt;
    logic [4:0]        w_pid_nxt;
    logic              w_fail_nxt;
    logic              w_locked_nxt;
    logic [2:0]        w_fails_inc;
    logic              w_id_ok;
    logic              w_pw_ok;
    logic              w_timeout;

    // Digit order 0..3 occupies bits [3:0], [7:4], [11:8], [15:12].
    function automatic logic [15:0] f_expected_pw(input logic [4:0] id);
        return {4'h5 ^ {3'b000, id[4]}, id[3:0] ^ 4'hA, ~id[3:0], id[3:0]};
    endfunction

    // Whole-entry compare; an invalid ID fails only after its full password was taken.
    assign w_id_ok     = (r_id != 5'd0) && ({1'b0, r_id} <= MAX_ID);
    assign w_pw_ok     = (r_digits == f_expected_pw(r_id));
    assign w_fails_inc = r_fails + 3'd1;

`ifdef AUTH_ENTRY_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [IDLE_W-1:0] r_idle_cnt;
    logic [IDLE_W-1:0] w_idle_nxt;

    assign w_timeout = (r_idle_cnt == IDLE_LAST);

    // Idle counter: runs only while dwelling in ID_LO/PW without a press.
    always_comb begin
        w_idle_nxt = '0;
        if ((r_state == ST_ID_LO || r_state == ST_PW) && (w_state_nxt == r_state) && !BtPass) begin
            w_idle_nxt = r_idle_cnt + IDLE_W'(1);
        end else begin
            w_idle_nxt = '0;
        end
    end

    // Idle counter register.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= w_idle_nxt;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state and next-output logic; BtLogout outranks BtPass, which outranks the timeout.
    always_comb begin
        w_state_nxt  = r_state;
        w_id_nxt     = r_id;
        w_digits_nxt = r_digits;
        w_dcnt_nxt   = r_dcnt;
        w_fails_nxt  = r_fails;
        w_lock_nxt   = r_lock_cnt;
        w_logged_nxt = r_logged_in;
        w_pid_nxt    = r_player_id;
        w_fail_nxt   = 1'b0;
        w_locked_nxt = r_locked;
        case (r_state)
            ST_ID_HI, ST_ID_LO, ST_PW: begin
                if (BtLogout || (w_timeout && !BtPass && r_state != ST_ID_HI)) begin
                    w_state_nxt  = ST_ID_HI;
                    w_id_nxt     = 5'd0;
                    w_digits_nxt = '0;
                    w_dcnt_nxt   = 3'd0;
                end else if (BtPass) begin
                    if (r_state == ST_ID_HI) begin
                        w_id_nxt[4] = SwPass[0];
                        w_state_nxt = ST_ID_LO;
                    end else if (r_state == ST_ID_LO) begin
                        w_id_nxt[3:0] = SwPass;
                        w_dcnt_nxt    = 3'd0;
                        w_state_nxt   = ST_PW;
                    end else begin
                        w_digits_nxt[r_dcnt[1:0]] = SwPass;
                        w_dcnt_nxt  = r_dcnt + 3'd1;
                        w_state_nxt = (r_dcnt == 3'd3) ? ST_CHECK : ST_PW;
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_CHECK: begin
                w_dcnt_nxt   = 3'd0;
                w_digits_nxt = '0;
                if (w_id_ok && w_pw_ok) begin
                    w_state_nxt  = ST_GRANTED;
                    w_logged_nxt = 1'b1;
                    w_pid_nxt    = r_id;
                    w_fails_nxt  = 3'd0;
                end else begin
                    w_fail_nxt  = 1'b1;
                    w_fails_nxt = w_fails_inc;
                    w_id_nxt    = 5'd0;
                    if (w_fails_inc >= FAIL_LIMIT) begin
                        w_state_nxt  = ST_LOCKED;
                        w_locked_nxt = 1'b1;
                        w_lock_nxt   = LOCK_LOAD;
                    end else begin
                        w_state_nxt = ST_ID_HI;
                    end
                end
            end
            ST_GRANTED: begin
                if (BtLogout && !GameBusy) begin
                    w_state_nxt  = ST_ID_HI;
                    w_logged_nxt = 1'b0;
                    w_pid_nxt    = 5'd0;
                    w_id_nxt     = 5'd0;
                end else begin
                    w_state_nxt = ST_GRANTED;
                end
            end
            ST_LOCKED: begin
                if (r_lock_cnt == '0) begin
                    w_state_nxt  = ST_ID_HI;
                    w_locked_nxt = 1'b0;
                    w_fails_nxt  = 3'd0;
                end else begin
                    w_lock_nxt = r_lock_cnt - LOCK_W'(1);
                end
            end
            default: begin
                w_state_nxt  = ST_ID_HI;
                w_id_nxt     = 5'd0;
                w_digits_nxt = '0;
                w_dcnt_nxt   = 3'd0;
                w_logged_nxt = 1'b0;
                w_pid_nxt    = 5'd0;
                w_locked_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state     <= ST_ID_HI;
            r_id        <= 5'd0;
            r_digits    <= '0;
            r_dcnt      <= 3'd0;
            r_fails     <= 3'd0;
            r_lock_cnt  <= '0;
            r_logged_in <= 1'b0;
            r_player_id <= 5'd0;
            r_auth_fail <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_id        <= w_id_nxt;
            r_digits    <= w_digits_nxt;
            r_dcnt      <= w_dcnt_nxt;
            r_fails     <= w_fails_nxt;
            r_lock_cnt  <= w_lock_nxt;
            r_logged_in <= w_logged_nxt;
            r_player_id <= w_pid_nxt;
            r_auth_fail <= w_fail_nxt;
            r_locked    <= w_locked_nxt;
        end
    end

    assign LoggedIn   = r_logged_in;
    assign PlayerID   = r_player_id;
    assign AuthState  = r_state;
    assign DigitCount = r_dcnt;
    assign AuthFail   = r_auth_fail;
    assign Locked     = r_locked;

endmodule
